bitwise_operand_fifo: RTL and testbench
=======================================

BITWISE_OPERAND_FIFO -- requirements
Module: bitwise_operand_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each operand (a, b).
REQ-002 SHALL have parameter DEPTH, default 4: number of operand-pair entries; a power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port in_valid, input, 1: the upstream operand pair is valid.
REQ-006 SHALL have port in_a, input, WIDTH: operand a to enqueue.
REQ-007 SHALL have port in_b, input, WIDTH: operand b to enqueue.
REQ-008 SHALL have port in_ready, output, 1: the FIFO can accept a pair this cycle.
REQ-009 SHALL have port out_valid, output, 1: the head pair is presented to the downstream bitwise gate array.
REQ-010 SHALL have port out_a, output, WIDTH: head operand a, feeding the gate-array a bus.
REQ-011 SHALL have port out_b, output, WIDTH: head operand b, feeding the gate-array b bus.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes the head pair this cycle.
REQ-013 SHALL have port count, output, log2(DEPTH)+1: number of occupied entries.

Function
REQ-014 Push SHALL occur on a rising edge where in_valid=1 and in_ready=1; {in_a,in_b} written at the write pointer, which then increments modulo DEPTH.
REQ-015 Pop SHALL occur on a rising edge where out_valid=1 and out_ready=1; the read pointer increments modulo DEPTH.
REQ-016 in_ready SHALL equal (count < DEPTH), decoded from registered state only; no combinational path from out_ready to in_ready.
REQ-017 out_valid SHALL equal (count != 0), decoded from registered state only.
REQ-018 out_a/out_b SHALL show the head entry (show-ahead) while out_valid=1, and SHALL be all-zero while out_valid=0.
REQ-019 Push-to-output latency SHALL be 1 cycle: a pair pushed into an empty FIFO at edge N is on out_a/out_b with out_valid=1 after edge N.
REQ-020 count SHALL change as follows:
- push only: +1
- pop only: -1
- push and pop together: unchanged
- neither: unchanged
REQ-021 Full (count=DEPTH): in_ready=0; in_valid is ignored even if a pop occurs in the same cycle; the pop still completes, and in_ready=1 the next cycle.
REQ-022 Empty (count=0): out_valid=0; out_ready is ignored; a push in that cycle still completes.
REQ-023 Push and pop together with 0<count<DEPTH SHALL both complete; both pointers advance.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss or reordering; output order SHALL equal push order.
REQ-025 in_a/in_b SHALL be held unchanged in the storage once written, regardless of later input changes.
REQ-026 Entry storage need not be reset; no output may depend on unwritten storage.

Reset
REQ-027 While rst_n=0 at a rising edge:
- count, write pointer and read pointer SHALL become 0.
- After the edge, out_valid=0, out_a=0, out_b=0, in_ready=1.
REQ-028 Reset mid-operation SHALL discard all stored pairs; pushes and pops in the reset cycle SHALL have no effect.
REQ-029 The first push SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-030 Reset then idle: after rst_n=0 for 2 cycles -> count=0, out_valid=0, out_a=out_b=0x00, in_ready=1.
REQ-031 Single pass: push (a=0xA5, b=0x0F) with out_ready=0 -> next cycle out_valid=1, out_a=0xA5, out_b=0x0F, count=1; then out_ready=1 for one cycle -> count=0, out_a=out_b=0x00.
REQ-032 Fill and overflow attempt: push 0x01..0x04 (b=~a), then in_valid=1 with a=0x55 -> in_ready=0, count=4, 0x55 never appears at the output; drain yields 0x01,0x02,0x03,0x04 in order.
REQ-033 Full with simultaneous push and pop: count=4, in_valid=1, out_ready=1 -> pop only, count=3; next cycle in_ready=1.
REQ-034 Wrap-around streaming: in_valid=out_ready=1 continuously for 10 pairs (a=0x10..0x19) -> output sequence 0x10..0x19 in order, count never exceeds 1, no drops.
REQ-035 Reset mid-stream: count=3, assert rst_n=0 for one edge with in_valid=out_ready=1 -> count=0, out_valid=0; a subsequent push of 0x7E is the next value output.

Source files
------------

// File: rtl/bitwise_operand_fifo_if.sv
//============================================================================
// Module      : bitwise_operand_fifo_if
// Description : Handshake bundle between an operand producer, the operand
//               FIFO and the downstream bitwise gate array.
//               Upstream : in_valid, in_a, in_b   -> FIFO, in_ready  <- FIFO
//               Downstream: out_valid, out_a, out_b <- FIFO, out_ready -> FIFO
//               Status   : count <- FIFO (occupied entries)
//               Modport slave  : the FIFO side.
//               Modport master : the environment driving/consuming the FIFO.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface bitwise_operand_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_a;
    logic [WIDTH-1:0]   out_b;
    logic               out_ready;
    logic [c_cnt_w-1:0] count;

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        output in_ready,
        output out_valid,
        output out_a,
        output out_b,
        input  out_ready,
        output count
    );

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        input  in_ready,
        input  out_valid,
        input  out_a,
        input  out_b,
        output out_ready,
        input  count
    );
endinterface

`default_nettype wire

// File: rtl/bitwise_operand_fifo.sv
//============================================================================
// Module      : bitwise_operand_fifo
// Description : Show-ahead FIFO of (a, b) operand pairs feeding a bitwise
//               gate array. One-cycle push-to-output latency, full
//               throughput with simultaneous push and pop, outputs forced
//               to zero while empty.
// Ports       : clk   - the only clock, rising edge
//               rst_n - synchronous active-low reset
//               bus   - bitwise_operand_fifo_if.slave (in_*, out_*, count)
// Parameters  : WIDTH - operand width
//               DEPTH - number of pair entries (power of two, >= 2)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module bitwise_operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input wire                        clk,
    input wire                        rst_n,
    bitwise_operand_fifo_if.slave     bus
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam int c_pair_w = 2 * WIDTH;

    localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

    // Pair storage: {a, b}. Not reset; only entries between the pointers
    // are ever visible, and the output mux zeroes the bus when empty.
    logic [c_pair_w-1:0] r_mem [DEPTH];

    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_push;
    logic                w_pop;
    logic [c_pair_w-1:0] w_head;

    // Both flags come straight from the registered count, so there is no
    // combinational path from out_ready back to in_ready. A full FIFO
    // therefore refuses a push even when a pop happens in the same cycle.
    assign w_in_ready  = (r_count < c_depth);
    assign w_out_valid = (r_count != '0);

    assign w_push = bus.in_valid  & w_in_ready;
    assign w_pop  = bus.out_ready & w_out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow gives the wrap.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Writes are suppressed during reset so a reset-cycle push leaves no
    // trace at all, not even in the (invisible) storage.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_a, bus.in_b};
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_a     = w_out_valid ? w_head[c_pair_w-1:WIDTH] : '0;
    assign bus.out_b     = w_out_valid ? w_head[WIDTH-1:0]        : '0;
    assign bus.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_bitwise_operand_fifo.sv
//============================================================================
// Module      : tb_bitwise_operand_fifo
// Description : Self-checking bench for bitwise_operand_fifo. Directed
//               scenarios followed by randomized traffic; a queue-based
//               reference model predicts occupancy and pair order, and a
//               monitor compares every presented head pair against it.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_bitwise_operand_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    int   n_checks;
    int   n_fail;

    // Reference model: the FIFO contents as a plain queue plus occupancy.
    logic [2*WIDTH-1:0] exp_q [$];
    int                 mcount;
    bit                 armed;

    bitwise_operand_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    bitwise_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each rising edge, from the inputs presented there.
    always @(posedge clk) begin
        bit push;
        bit pop;
        if (!rst_n) begin
            mcount = 0;
            exp_q.delete();
            armed  = 1'b1;
        end else if (armed) begin
            push = bus.in_valid && (mcount < DEPTH);
            pop  = bus.out_ready && (mcount > 0);
            if (push) exp_q.push_back({bus.in_a, bus.in_b});
            mcount = mcount + int'(push) - int'(pop);
        end
    end

    // Monitor: mid-cycle, compare status and the presented head pair.
    always @(negedge clk) begin
        if (armed) begin
            chk("count",     32'(bus.count),     32'(mcount));
            chk("in_ready",  32'(bus.in_ready),  32'(mcount < DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(mcount > 0));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL head: got 0x%0h, expected nothing (model empty) at %0t",
                             {bus.out_a, bus.out_b}, $time);
                end else begin
                    chk("head", 32'({bus.out_a, bus.out_b}), 32'(exp_q[0]));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_out", 32'({bus.out_a, bus.out_b}), 32'h0);
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit r, input bit rn);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = r;
        rst_n         = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mcount   = 0;
        armed    = 1'b0;

        // Reset then idle
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 0, 1);
        chk("rst_count",     32'(bus.count),     0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_ab",    32'({bus.out_a, bus.out_b}), 0);
        chk("rst_in_ready",  32'(bus.in_ready),  1);

        // Single pass
        step(1, 8'hA5, 8'h0F, 0, 1);
        chk("single_valid", 32'(bus.out_valid), 1);
        chk("single_a",     32'(bus.out_a),     32'h A5);
        chk("single_b",     32'(bus.out_b),     32'h0F);
        chk("single_count", 32'(bus.count),     1);
        step(0, 8'h00, 8'h00, 1, 1);
        chk("single_pop_count", 32'(bus.count), 0);
        chk("single_pop_ab",    32'({bus.out_a, bus.out_b}), 0);

        // Fill, then overflow attempt
        for (int i = 1; i <= 4; i++) step(1, 8'(i), ~8'(i), 0, 1);
        chk("full_count",    32'(bus.count),    4);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        step(1, 8'h55, 8'hAA, 0, 1);
        chk("ovf_count", 32'(bus.count), 4);
        chk("ovf_head",  32'(bus.out_a), 32'h01);

        // Full with simultaneous push and pop: pop only
        step(1, 8'h55, 8'hAA, 1, 1);
        chk("fullpp_count",    32'(bus.count),    3);
        chk("fullpp_in_ready", 32'(bus.in_ready), 1);
        for (int i = 2; i <= 4; i++) begin
            chk("drain_order", 32'(bus.out_a), 32'(i));
            step(0, 8'h00, 8'h00, 1, 1);
        end
        chk("drain_empty", 32'(bus.count), 0);

        // Wrap-around streaming
        for (int i = 0; i < 10; i++) begin
            step(1, 8'h10 + 8'(i), 8'hF0 - 8'(i), 1, 1);
            chk("stream_count", 32'(bus.count), 1);
            chk("stream_head",  32'(bus.out_a), 32'h10 + 32'(i));
        end
        step(0, 8'h00, 8'h00, 1, 1);
        chk("stream_end", 32'(bus.count), 0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 8'h00, 0, 1);
        chk("midrst_pre", 32'(bus.count), 3);
        step(1, 8'h11, 8'h22, 1, 0);
        chk("midrst_count", 32'(bus.count),     0);
        chk("midrst_valid", 32'(bus.out_valid), 0);
        step(1, 8'h7E, 8'h81, 0, 1);
        chk("midrst_next_a", 32'(bus.out_a), 32'h7E);
        chk("midrst_next_b", 32'(bus.out_b), 32'h81);
        step(0, 8'h00, 8'h00, 1, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 39) != 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, 8'h00, 8'h00, 1, 1);
        chk("final_count",  32'(bus.count), 0);
        chk("final_sb_len", 32'(exp_q.size()), 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
